// File: rtl/fir_coef_load_sequencer_if.sv
// Bus bundle for the FIR coefficient load sequencer: UART byte input,
// load/send buttons, FIFO flags, and the coefficient / FIFO control outputs.
interface fir_coef_load_sequencer_if #(
   parameter int N_COEF = 16,
   parameter int COEF_W = 12
);
   logic                       load_req_i;
   logic                       send_i;
   logic [7:0]                 rx_data_i;
   logic                       rx_valid_i;
   logic                       full_fifo_i;
   logic                       empty_i;
   logic [N_COEF*COEF_W-1:0]   coef_o;
   logic                       coef_valid_o;
   logic                       en_fir_o;
   logic                       wr_o;
   logic                       rd_o;
   logic                       led_full_o;
   logic                       busy_o;
   logic                       err_o;

   // Side that issues requests and bytes and watches the results
   modport master (
      output load_req_i, send_i, rx_data_i, rx_valid_i, full_fifo_i, empty_i,
      input  coef_o, coef_valid_o, en_fir_o, wr_o, rd_o, led_full_o, busy_o, err_o
   );

   // Side implemented by the sequencer itself
   modport slave (
      input  load_req_i, send_i, rx_data_i, rx_valid_i, full_fifo_i, empty_i,
      output coef_o, coef_valid_o, en_fir_o, wr_o, rd_o, led_full_o, busy_o, err_o
   );
endinterface

// File: rtl/fir_coef_load_sequencer.sv
// FIR coefficient load sequencer: assembles UART bytes (low byte first) into a
// shadow bank, commits the whole bank to the FIR in one edge, then runs the
// capture-into-FIFO / drain-to-PC cycle. Aborted loads never touch coef_o.
module fir_coef_load_sequencer #(
   parameter int N_COEF  = 16,
   parameter int COEF_W  = 12,
   parameter int TIMEOUT = 1_000_000
) (
   input logic                      clk_i,
   input logic                      rst_i,
   fir_coef_load_sequencer_if.slave bus
);

   localparam int         IW      = (N_COEF > 1) ? $clog2(N_COEF) : 1;
   localparam int         TW      = $clog2(TIMEOUT + 1);
   localparam logic [7:0] HI_MASK = 8'hFF << (COEF_W - 8);

   typedef enum logic [2:0] {
      IDLE,
      RX_LO,
      RX_HI,
      COMMIT,
      CAPTURE,
      FULL,
      DRAIN
   } state_t;

   state_t                   r_state;
   state_t                   w_nextState;
   logic [IW-1:0]            r_idx;
   logic [7:0]               r_lo;
   logic [TW-1:0]            r_timer;
   logic [COEF_W-1:0]        r_shadow [N_COEF];
   logic [N_COEF*COEF_W-1:0] r_coef;
   logic                     r_coefValid;
   logic                     r_enFir;
   logic                     r_busy;
   logic                     r_ledFull;
   logic                     r_err;

   logic                     w_startLoad;
   logic                     w_latchLo;
   logic                     w_writeShadow;
   logic                     w_advanceIdx;
   logic                     w_commit;
   logic                     w_abort;
   logic                     w_timeout;
   logic                     w_hiBad;
   logic                     w_lastIdx;
   logic                     w_rxState;
   logic [COEF_W-1:0]        w_coefWord;

   assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));
   assign w_hiBad    = |(bus.rx_data_i & HI_MASK);
   assign w_coefWord = {bus.rx_data_i[COEF_W-9:0], r_lo};
   assign w_lastIdx  = (r_idx == IW'(N_COEF - 1));
   assign w_rxState  = (r_state == RX_LO) || (r_state == RX_HI);

   // State register; reset drops straight back to IDLE
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode plus the one-cycle strobes that steer the datapath.
   // A byte strobe wins over a coincident timeout because it proves the link is alive.
   always_comb begin
      w_nextState   = r_state;
      w_startLoad   = 1'b0;
      w_latchLo     = 1'b0;
      w_writeShadow = 1'b0;
      w_advanceIdx  = 1'b0;
      w_commit      = 1'b0;
      w_abort       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.load_req_i) begin
               w_startLoad = 1'b1;
               w_nextState = RX_LO;
            end
         end
         RX_LO: begin
            if (bus.rx_valid_i) begin
               w_latchLo   = 1'b1;
               w_nextState = RX_HI;
            end else if (w_timeout) begin
               w_abort     = 1'b1;
               w_nextState = IDLE;
            end
         end
         RX_HI: begin
            if (bus.rx_valid_i) begin
               if (w_hiBad) begin
                  w_abort     = 1'b1;
                  w_nextState = IDLE;
               end else begin
                  w_writeShadow = 1'b1;
                  if (w_lastIdx) begin
                     w_nextState = COMMIT;
                  end else begin
                     w_advanceIdx = 1'b1;
                     w_nextState  = RX_LO;
                  end
               end
            end else if (w_timeout) begin
               w_abort     = 1'b1;
               w_nextState = IDLE;
            end
         end
         COMMIT: begin
            w_commit    = 1'b1;
            w_nextState = CAPTURE;
         end
         CAPTURE: begin
            if (bus.load_req_i) begin
               w_startLoad = 1'b1;
               w_nextState = RX_LO;
            end else if (bus.full_fifo_i) begin
               w_nextState = FULL;
            end
         end
         FULL: begin
            if (bus.load_req_i) begin
               w_startLoad = 1'b1;
               w_nextState = RX_LO;
            end else if (bus.send_i) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.load_req_i) begin
               w_startLoad = 1'b1;
               w_nextState = RX_LO;
            end else if (bus.empty_i) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Byte assembly: coefficient index, pending low byte, inter-byte timer and shadow bank
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_idx   <= '0;
         r_lo    <= '0;
         r_timer <= '0;
         for (int k = 0; k < N_COEF; k++) begin
            r_shadow[k] <= '0;
         end
      end else begin
         if (w_startLoad) begin
            r_idx <= '0;
         end else if (w_advanceIdx) begin
            r_idx <= r_idx + IW'(1);
         end
         if (w_latchLo) begin
            r_lo <= bus.rx_data_i;
         end
         if (w_writeShadow) begin
            r_shadow[r_idx] <= w_coefWord;
         end
         if (w_startLoad || bus.rx_valid_i) begin
            r_timer <= '0;
         end else if (w_rxState) begin
            r_timer <= r_timer + TW'(1);
         end
      end
   end

   // Atomic commit: the whole shadow bank lands on coef_o in a single edge
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_coef      <= '0;
         r_coefValid <= 1'b0;
      end else if (w_commit) begin
         for (int k = 0; k < N_COEF; k++) begin
            r_coef[k*COEF_W +: COEF_W] <= r_shadow[k];
         end
         r_coefValid <= 1'b1;
      end
   end

   // Registered status outputs, decoded from the state being entered so they line up with it
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_ledFull <= 1'b0;
         r_enFir   <= 1'b0;
      end else begin
         if (w_abort) begin
            r_err <= 1'b1;
         end else if (w_startLoad) begin
            r_err <= 1'b0;
         end
         r_busy    <= (w_nextState == RX_LO) || (w_nextState == RX_HI);
         r_ledFull <= (w_nextState == FULL);
         r_enFir   <= (w_nextState == IDLE) ? r_coefValid
                    : ((w_nextState == CAPTURE) || (w_nextState == FULL) || (w_nextState == DRAIN));
      end
   end

   assign bus.coef_o       = r_coef;
   assign bus.coef_valid_o = r_coefValid;
   assign bus.en_fir_o     = r_enFir;
   assign bus.led_full_o   = r_ledFull;
   assign bus.busy_o       = r_busy;
   assign bus.err_o        = r_err;
   assign bus.wr_o         = (r_state == CAPTURE) & ~bus.full_fifo_i;
   assign bus.rd_o         = (r_state == DRAIN) & ~bus.empty_i;

endmodule

// File: tb/tb_fir_coef_load_sequencer.sv
// Testbench for fir_coef_load_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all checked each cycle against a
// byte-queue model of the load / capture / drain behaviour.
module tb_fir_coef_load_sequencer;

   localparam int N_COEF  = 16;
   localparam int COEF_W  = 12;
   localparam int TIMEOUT = 100;
   localparam int CW      = N_COEF * COEF_W;

   // Coefficient k = k-8, two's complement, coefficient 0 in the low bits
   localparam logic [CW-1:0] LIT_A = 192'h007006005004003002001000FFFFFEFFDFFCFFBFFAFF9FF8;

   typedef enum {M_IDLE, M_LOAD, M_COMMIT, M_CAPTURE, M_FULL, M_DRAIN} mode_t;

   logic clk_i;
   logic rst_i;
   int   checks;
   int   errors;

   fir_coef_load_sequencer_if #(.N_COEF(N_COEF), .COEF_W(COEF_W)) bus ();

   fir_coef_load_sequencer #(
      .N_COEF (N_COEF),
      .COEF_W (COEF_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Model: bytes received so far in this load, silent-cycle count, committed set
   mode_t         mMode;
   logic [7:0]    mBytes[$];
   int            mQuiet;
   logic          mValid;
   logic          mErr;
   logic [CW-1:0] mCoef;

   task automatic cmp(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelStartLoad();
      mBytes.delete();
      mQuiet = 0;
      mErr   = 1'b0;
      mMode  = M_LOAD;
   endtask

   task automatic modelAbort();
      mErr  = 1'b1;
      mMode = M_IDLE;
   endtask

   // Advance the model across the clock edge that just happened, using the
   // inputs that were presented to that edge
   task automatic modelStep();
      int val;
      if (!rst_i) begin
         mMode = M_IDLE;
         mBytes.delete();
         mQuiet = 0;
         mValid = 1'b0;
         mErr   = 1'b0;
         mCoef  = '0;
      end else begin
         case (mMode)
            M_IDLE: if (bus.load_req_i) modelStartLoad();
            M_LOAD: begin
               if (bus.rx_valid_i) begin
                  mQuiet = 0;
                  if ((mBytes.size() % 2 == 1) && ((int'(bus.rx_data_i) >> (COEF_W - 8)) != 0)) begin
                     modelAbort();
                  end else begin
                     mBytes.push_back(bus.rx_data_i);
                     if (mBytes.size() == 2 * N_COEF) mMode = M_COMMIT;
                  end
               end else begin
                  mQuiet++;
                  if (mQuiet == TIMEOUT) modelAbort();
               end
            end
            M_COMMIT: begin
               for (int k = 0; k < N_COEF; k++) begin
                  val = int'(mBytes[2*k]) + 256 * int'(mBytes[2*k+1]);
                  mCoef[k*COEF_W +: COEF_W] = COEF_W'(val);
               end
               mValid = 1'b1;
               mMode  = M_CAPTURE;
            end
            M_CAPTURE: begin
               if (bus.load_req_i) modelStartLoad();
               else if (bus.full_fifo_i) mMode = M_FULL;
            end
            M_FULL: begin
               if (bus.load_req_i) modelStartLoad();
               else if (bus.send_i) mMode = M_DRAIN;
            end
            M_DRAIN: begin
               if (bus.load_req_i) modelStartLoad();
               else if (bus.empty_i) mMode = M_IDLE;
            end
            default: mMode = M_IDLE;
         endcase
      end
   endtask

   task automatic checkOutput();
      logic expEn;
      expEn = (mMode == M_IDLE) ? mValid
            : ((mMode == M_CAPTURE) || (mMode == M_FULL) || (mMode == M_DRAIN));
      cmp("coef_o",       bus.coef_o,       mCoef);
      cmp("coef_valid_o", CW'(bus.coef_valid_o), CW'(mValid));
      cmp("en_fir_o",     CW'(bus.en_fir_o),     CW'(expEn));
      cmp("busy_o",       CW'(bus.busy_o),       CW'(mMode == M_LOAD));
      cmp("led_full_o",   CW'(bus.led_full_o),   CW'(mMode == M_FULL));
      cmp("err_o",        CW'(bus.err_o),        CW'(mErr));
      cmp("wr_o",         CW'(bus.wr_o),         CW'((mMode == M_CAPTURE) && !bus.full_fifo_i));
      cmp("rd_o",         CW'(bus.rd_o),         CW'((mMode == M_DRAIN) && !bus.empty_i));
   endtask

   // Compare process: just after each falling edge, step the model then check every output
   initial begin
      forever begin
         @(negedge clk_i);
         #1;
         modelStep();
         checkOutput();
      end
   end

   // Drive one cycle's worth of pulses, starting 2 time units after a falling edge
   task automatic applyStimulus(input logic ld, input logic sd, input logic rv, input logic [7:0] d);
      bus.load_req_i = ld;
      bus.send_i     = sd;
      bus.rx_valid_i = rv;
      bus.rx_data_i  = d;
      @(negedge clk_i);
      #2;
      bus.load_req_i = 1'b0;
      bus.send_i     = 1'b0;
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Issue a load request then the first nBytes bytes of the given set, low byte first
   task automatic loadFlat(input logic [CW-1:0] flat, input int nBytes);
      logic [COEF_W-1:0] v;
      logic [7:0]        b;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < nBytes; i++) begin
         v = flat[(i/2)*COEF_W +: COEF_W];
         b = (i % 2 == 0) ? v[7:0] : 8'(v >> 8);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         applyStimulus(1'b0, 1'b0, 1'b1, b);
      end
   endtask

   initial begin
      logic [CW-1:0] setB;
      logic          ld, sd, rv;
      logic [7:0]    d;
      logic [7:0]    hiOk;
      checks = 0;
      errors = 0;
      hiOk   = 8'((1 << (COEF_W - 8)) - 1);
      rst_i  = 1'b0;
      bus.load_req_i  = 1'b0;
      bus.send_i      = 1'b0;
      bus.rx_valid_i  = 1'b0;
      bus.rx_data_i   = 8'h00;
      bus.full_fifo_i = 1'b0;
      bus.empty_i     = 1'b0;
      @(negedge clk_i);
      #2;

      // T1: reset state, then the k-8 ramp
      $display("[TB] T1 reset and ramp load");
      cmp("reset_coef", bus.coef_o, '0);
      cmp("reset_flags", CW'({bus.coef_valid_o, bus.en_fir_o, bus.wr_o, bus.rd_o,
                              bus.led_full_o, bus.busy_o, bus.err_o}), '0);
      rst_i = 1'b1;
      idle(2);
      loadFlat(LIT_A, 2 * N_COEF);
      cmp("t1_valid_in_commit", CW'(bus.coef_valid_o), CW'(0));
      idle(1);
      cmp("t1_coef", bus.coef_o, LIT_A);
      cmp("t1_valid", CW'(bus.coef_valid_o), CW'(1));
      cmp("t1_wr", CW'(bus.wr_o), CW'(1));
      idle(3);

      // T2: full stops writes at once, send drains until empty
      $display("[TB] T2 capture, full, drain");
      bus.full_fifo_i = 1'b1;
      #1;
      cmp("t2_wr_on_full", CW'(bus.wr_o), CW'(0));
      idle(1);
      cmp("t2_led_full", CW'(bus.led_full_o), CW'(1));
      bus.full_fifo_i = 1'b0;
      idle(2);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      cmp("t2_rd", CW'(bus.rd_o), CW'(1));
      cmp("t2_led_off", CW'(bus.led_full_o), CW'(0));
      idle(2);
      bus.empty_i = 1'b1;
      #1;
      cmp("t2_rd_on_empty", CW'(bus.rd_o), CW'(0));
      idle(1);
      cmp("t2_idle_en", CW'(bus.en_fir_o), CW'(1));
      cmp("t2_idle_busy", CW'(bus.busy_o), CW'(0));
      bus.empty_i = 1'b0;

      // T3: a load that stalls after 10 bytes times out and leaves set A in place
      $display("[TB] T3 timeout");
      for (int k = 0; k < N_COEF; k++) setB[k*COEF_W +: COEF_W] = COEF_W'($urandom);
      loadFlat(setB, 10);
      idle(TIMEOUT - 1);
      cmp("t3_err_before", CW'(bus.err_o), CW'(0));
      cmp("t3_busy_before", CW'(bus.busy_o), CW'(1));
      idle(1);
      cmp("t3_err", CW'(bus.err_o), CW'(1));
      cmp("t3_busy", CW'(bus.busy_o), CW'(0));
      cmp("t3_coef_kept", bus.coef_o, LIT_A);

      // T4: illegal high byte aborts; a following good load clears the error
      $display("[TB] T4 bad high byte");
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      cmp("t4_err_cleared", CW'(bus.err_o), CW'(0));
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h34);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h1F);
      cmp("t4_err", CW'(bus.err_o), CW'(1));
      cmp("t4_busy", CW'(bus.busy_o), CW'(0));
      cmp("t4_coef_kept", bus.coef_o, LIT_A);
      loadFlat(setB, 2 * N_COEF);
      idle(1);
      cmp("t4_coef_b", bus.coef_o, setB);
      cmp("t4_err_ok", CW'(bus.err_o), CW'(0));

      // T5: load request beats send while FULL
      $display("[TB] T5 load beats send");
      bus.full_fifo_i = 1'b1;
      idle(1);
      cmp("t5_led_full", CW'(bus.led_full_o), CW'(1));
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      cmp("t5_busy", CW'(bus.busy_o), CW'(1));
      cmp("t5_rd", CW'(bus.rd_o), CW'(0));
      bus.full_fifo_i = 1'b0;
      idle(TIMEOUT);
      cmp("t5_err", CW'(bus.err_o), CW'(1));
      cmp("t5_coef_kept", bus.coef_o, setB);

      // T6: reset in the middle of a load wipes everything
      $display("[TB] T6 reset mid-load");
      loadFlat(LIT_A, 1);
      rst_i = 1'b0;
      #1;
      cmp("t6_valid", CW'(bus.coef_valid_o), CW'(0));
      cmp("t6_en", CW'(bus.en_fir_o), CW'(0));
      cmp("t6_coef", bus.coef_o, '0);
      idle(1);
      rst_i = 1'b1;
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
      cmp("t6_coef_after", bus.coef_o, '0);
      cmp("t6_valid_after", CW'(bus.coef_valid_o), CW'(0));

      // Randomized traffic; high bytes mostly legal so loads complete
      $display("[TB] random traffic");
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 499) == 0) idle(TIMEOUT + 20);
         ld = ($urandom_range(0, 199) == 0);
         sd = ($urandom_range(0, 7) == 0);
         rv = 1'($urandom_range(0, 1));
         d  = 8'($urandom);
         if ((mBytes.size() % 2 == 1) && ($urandom_range(0, 59) != 0)) d = d & hiOk;
         bus.full_fifo_i = ($urandom_range(0, 9) == 0);
         bus.empty_i     = ($urandom_range(0, 5) == 0);
         applyStimulus(ld, sd, rv, d);
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
